// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt mask unit.
package irq_pkg;

  localparam int NUM_IRQ_DEF   = 8;
  localparam int IRQ_MAX       = 32;
  localparam int IRQ_IDX_MAX_W = 5;

  // OCW1 is the whole-word mask write of the legacy 8-channel controller
  localparam int           OCW1_W        = 8;
  localparam logic [7:0]   OCW1_MASK_ALL = 8'hFF;
  localparam logic [7:0]   OCW1_MASK_NONE = 8'h00;

  typedef logic [NUM_IRQ_DEF-1:0] irq_vec_t;

  // Returns {found, idx} for the lowest set bit (channel 0 = highest priority)
  function automatic logic [IRQ_IDX_MAX_W:0] lowest_set_idx(input logic [IRQ_MAX-1:0] vec);
    logic [IRQ_IDX_MAX_W:0] r;
    r = '0;
    for (int i = IRQ_MAX - 1; i >= 0; i--)
      if (vec[i]) r = {1'b1, IRQ_IDX_MAX_W'(i)};
    return r;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index priority encoder, W up to 32 channels.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int W     = NUM_IRQ_DEF,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     vec,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IRQ_IDX_MAX_W:0] res;

  assign res   = lowest_set_idx(IRQ_MAX'(vec));
  assign found = res[IRQ_IDX_MAX_W];
  assign idx   = IDX_W'(res[IRQ_IDX_MAX_W-1:0]);

endmodule

// File: rtl/irq_mask_unit.sv
// Interrupt mask register, request latch and nesting-aware pending selector.
// Optional: define IRQ_SPECIAL_MASK_MODE_EN to add the smm (special mask mode) input.
module irq_mask_unit
  import irq_pkg::*;
#(
  parameter int                 NUM_IRQ = NUM_IRQ_DEF,
  parameter int                 ID_W    = $clog2(NUM_IRQ),
  parameter logic [NUM_IRQ-1:0] IMR_RST = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               imr_wr_en,
  input  logic [NUM_IRQ-1:0] imr_wr_data,
  input  logic [NUM_IRQ-1:0] imr_set,
  input  logic [NUM_IRQ-1:0] imr_clr,
  input  logic               level_mode,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] isr_in,
`ifdef IRQ_SPECIAL_MASK_MODE_EN
  input  logic               smm,
`endif
  input  logic               ack_valid,
  input  logic [ID_W-1:0]    ack_id,
  output logic [NUM_IRQ-1:0] imr_out,
  output logic [NUM_IRQ-1:0] irr_out,
  output logic [NUM_IRQ-1:0] pend_vec,
  output logic               pend_valid,
  output logic [ID_W-1:0]    pend_id
);

  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] imr_next, irr_next, ack_mask, unmasked, isr_eff;
  logic               p_found, s_found;
  logic [ID_W-1:0]    p_idx, s_idx;
  logic               pend_next;

  // Decode acknowledge into a one-hot clear mask; out-of-range ids hit nothing
  always_comb begin
    ack_mask = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      ack_mask[i] = ack_valid && (ack_id == ID_W'(i));
  end

  // Next IMR: full write wins; otherwise set beats clear on the same bit
  always_comb begin
    imr_next = (imr_out | imr_set) & ~(imr_clr & ~imr_set);
    if (imr_wr_en) imr_next = imr_wr_data;
  end

  // Next IRR: level follows the line; edge latches rises and drops acked bits,
  // a fresh rise in the ack cycle keeps the bit so the new request survives
  always_comb begin
    if (level_mode) irr_next = irq_in;
    else            irr_next = (irr_out & ~ack_mask) | (irq_in & ~irq_prev);
  end

  assign unmasked = irr_next & ~imr_next;

`ifdef IRQ_SPECIAL_MASK_MODE_EN
  // In special mask mode a masked in-service channel no longer blocks lower ones
  assign isr_eff = smm ? (isr_in & ~imr_next) : isr_in;
`else
  assign isr_eff = isr_in;
`endif

  irq_prio_enc #(.W(NUM_IRQ), .IDX_W(ID_W)) u_enc_p (
    .vec   (unmasked),
    .found (p_found),
    .idx   (p_idx)
  );

  irq_prio_enc #(.W(NUM_IRQ), .IDX_W(ID_W)) u_enc_s (
    .vec   (isr_eff),
    .found (s_found),
    .idx   (s_idx)
  );

  // Only a request strictly above the highest in-service channel may nest
  assign pend_next = p_found && (!s_found || (p_idx < s_idx));

  // All architectural state and outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imr_out    <= IMR_RST;
      irr_out    <= '0;
      irq_prev   <= '0;
      pend_vec   <= '0;
      pend_valid <= 1'b0;
      pend_id    <= '0;
    end else begin
      imr_out    <= imr_next;
      irr_out    <= irr_next;
      irq_prev   <= irq_in;
      pend_vec   <= unmasked;
      pend_valid <= pend_next;
      pend_id    <= pend_next ? p_idx : '0;
    end
  end

endmodule

// File: tb/tb_irq_mask_unit.sv
// Directed bench for irq_mask_unit: 8-channel instance plus a 16-channel instance.
module tb_irq_mask_unit;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-channel DUT signals
  logic       rst_n, imr_wr_en, level_mode, ack_valid, smm;
  logic [7:0] imr_wr_data, imr_set, imr_clr, irq_in, isr_in;
  logic [2:0] ack_id, pend_id;
  logic [7:0] imr_out, irr_out, pend_vec;
  logic       pend_valid;

  // 16-channel DUT signals
  logic        w_rst_n, w_imr_wr_en, w_level_mode, w_ack_valid, w_smm;
  logic [15:0] w_imr_wr_data, w_imr_set, w_imr_clr, w_irq_in, w_isr_in;
  logic [3:0]  w_ack_id, w_pend_id;
  logic [15:0] w_imr_out, w_irr_out, w_pend_vec;
  logic        w_pend_valid;

  irq_mask_unit #(.NUM_IRQ(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .imr_wr_en(imr_wr_en), .imr_wr_data(imr_wr_data),
    .imr_set(imr_set), .imr_clr(imr_clr), .level_mode(level_mode), .irq_in(irq_in),
    .isr_in(isr_in),
`ifdef IRQ_SPECIAL_MASK_MODE_EN
    .smm(smm),
`endif
    .ack_valid(ack_valid), .ack_id(ack_id), .imr_out(imr_out), .irr_out(irr_out),
    .pend_vec(pend_vec), .pend_valid(pend_valid), .pend_id(pend_id)
  );

  irq_mask_unit #(.NUM_IRQ(16)) u_dut16 (
    .clk(clk), .rst_n(w_rst_n), .imr_wr_en(w_imr_wr_en), .imr_wr_data(w_imr_wr_data),
    .imr_set(w_imr_set), .imr_clr(w_imr_clr), .level_mode(w_level_mode), .irq_in(w_irq_in),
    .isr_in(w_isr_in),
`ifdef IRQ_SPECIAL_MASK_MODE_EN
    .smm(w_smm),
`endif
    .ack_valid(w_ack_valid), .ack_id(w_ack_id), .imr_out(w_imr_out), .irr_out(w_irr_out),
    .pend_vec(w_pend_vec), .pend_valid(w_pend_valid), .pend_id(w_pend_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one edge; outputs are then sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_imr(input logic [7:0] d);
    imr_wr_en = 1'b1; imr_wr_data = d;
    tick();
    imr_wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; imr_wr_en = 1'b1; imr_wr_data = 8'h00; imr_set = '0; imr_clr = '0;
    level_mode = 1'b0; irq_in = '0; isr_in = '0; ack_valid = 1'b0; ack_id = '0; smm = 1'b0;
    w_rst_n = 1'b0; w_imr_wr_en = 1'b0; w_imr_wr_data = '0; w_imr_set = '0; w_imr_clr = '0;
    w_level_mode = 1'b0; w_irq_in = '0; w_isr_in = '0; w_ack_valid = 1'b0; w_ack_id = '0;
    w_smm = 1'b0;

    // reset overrides a concurrent IMR write
    tick();
    chk("rst_imr", imr_out, 8'hFF);
    chk("rst_irr", irr_out, 8'h00);
    chk("rst_pvld", pend_valid, 1'b0);
    chk("rst_pvec", pend_vec, 8'h00);
    chk("rst_pid", pend_id, 3'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_imr", imr_out, 8'h00);
    imr_wr_en = 1'b0;

    // mask set/clear precedence
    wr_imr(8'hF0);
    chk("imr_f0", imr_out, 8'hF0);
    imr_set = 8'h01; imr_clr = 8'h81;
    tick();
    chk("imr_setclr", imr_out, 8'h71);
    imr_wr_en = 1'b1; imr_wr_data = 8'h3C;
    tick();
    chk("imr_wr_wins", imr_out, 8'h3C);
    imr_wr_en = 1'b0; imr_set = '0; imr_clr = '0;

    // edge latch while masked, then unmask, then ack
    wr_imr(8'h08);
    irq_in = 8'h08;
    tick();
    chk("edge_irr", irr_out, 8'h08);
    chk("edge_masked_pvld", pend_valid, 1'b0);
    wr_imr(8'h00);
    chk("unmask_pvld", pend_valid, 1'b1);
    chk("unmask_pid", pend_id, 3'd3);
    chk("unmask_pvec", pend_vec, 8'h08);
    ack_valid = 1'b1; ack_id = 3'd3;
    tick();
    ack_valid = 1'b0;
    chk("ack3_irr", irr_out, 8'h00);
    chk("ack3_pvld", pend_valid, 1'b0);

    // ack/edge collision on channel 2
    irq_in = 8'h0C;
    tick();
    chk("coll_rise_irr", irr_out, 8'h04);
    chk("coll_rise_pid", pend_id, 3'd2);
    irq_in = 8'h08;
    tick();
    chk("coll_fall_irr", irr_out, 8'h04);
    irq_in = 8'h0C; ack_valid = 1'b1; ack_id = 3'd2;
    tick();
    chk("coll_irr", irr_out, 8'h04);
    tick();
    ack_valid = 1'b0;
    chk("ack2_plain_irr", irr_out, 8'h00);

    // nesting against in-service
    irq_in = 8'h30; isr_in = 8'h10;
    tick();
    chk("nest_irr", irr_out, 8'h30);
    chk("nest_blk_pvld", pend_valid, 1'b0);
    isr_in = 8'h40;
    tick();
    chk("nest_ok_pvld", pend_valid, 1'b1);
    chk("nest_ok_pid", pend_id, 3'd4);
    isr_in = 8'h00; ack_valid = 1'b1; ack_id = 3'd4;
    tick();
    ack_valid = 1'b0;
    chk("ack4_irr", irr_out, 8'h20);
    chk("ack4_pid", pend_id, 3'd5);
    isr_in = 8'h01;
    wr_imr(8'h01);
    chk("masked_isr_blocks", pend_valid, 1'b0);
`ifdef IRQ_SPECIAL_MASK_MODE_EN
    smm = 1'b1;
    tick();
    chk("smm_pvld", pend_valid, 1'b1);
    chk("smm_pid", pend_id, 3'd5);
    smm = 1'b0;
`endif
    isr_in = 8'h00;
    wr_imr(8'h00);

    // level mode, ack ignored, mode toggle keeps IRR, then reset mid-operation
    level_mode = 1'b1; irq_in = 8'h81;
    tick();
    chk("lvl_irr", irr_out, 8'h81);
    chk("lvl_pid", pend_id, 3'd0);
    ack_valid = 1'b1; ack_id = 3'd0;
    tick();
    ack_valid = 1'b0;
    chk("lvl_ack_irr", irr_out, 8'h81);
    irq_in = 8'h00;
    tick();
    chk("lvl_drop_irr", irr_out, 8'h00);
    irq_in = 8'h81;
    tick();
    level_mode = 1'b0;
    tick();
    chk("toggle_keep_irr", irr_out, 8'h81);
    chk("pre_rst_pvld", pend_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_imr", imr_out, 8'hFF);
    chk("mid_rst_irr", irr_out, 8'h00);
    chk("mid_rst_pvec", pend_vec, 8'h00);
    chk("mid_rst_pvld", pend_valid, 1'b0);
    chk("mid_rst_pid", pend_id, 3'd0);

    // 16-channel instance, top channel
    w_rst_n = 1'b1; w_imr_wr_en = 1'b1; w_imr_wr_data = 16'h0000;
    tick();
    w_imr_wr_en = 1'b0;
    chk("w_imr", w_imr_out, 16'h0000);
    w_irq_in = 16'h8000;
    tick();
    chk("w_irr", w_irr_out, 16'h8000);
    chk("w_pvld", w_pend_valid, 1'b1);
    chk("w_pid", w_pend_id, 4'd15);
    chk("w_pvec", w_pend_vec, 16'h8000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
